// File: rtl/conv_weight_fetch_if.sv
// Weight stream from the fetch unit to the conv PE array's weight loader.
// Valid/ready handshake; a word transfers when valid & ready.
interface conv_weight_fetch_if #(
   parameter int DATA_WIDTH = 144
);
   logic [DATA_WIDTH-1:0] data;   // nine 16-bit taps, tap k in [16k+15:16k]
   logic                  valid;
   logic                  ready;
   logic                  last;   // marks the final word of a burst

   modport master (output data, output valid, output last, input ready);
   modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/conv_weight_fetch.sv
// Read-side initiator for the convolution weight ROMs. A start command
// launches a burst of sequential ROM reads; the fixed ROM latency is
// absorbed by a small credit-controlled FIFO that feeds the weight stream.
module conv_weight_fetch #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 144,          // 3x3 kernel of 16-bit weights
   parameter int ROM_LAT    = 1,            // 1: plain ROM, 2: registered output
   parameter int BUF_DEPTH  = ROM_LAT + 1   // smallest depth sustaining 1 word/cycle
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   word_cnt,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_rd_data,
   conv_weight_fetch_if.master   w,
   output logic                  busy,
   output logic                  done
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);
   localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH + 1)'(1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

   state_t                state;
   logic [ADDR_WIDTH:0]   issue_left;    // addresses still to issue
   logic [ADDR_WIDTH:0]   accept_left;   // words still to be accepted downstream
   logic [ROM_LAT-1:0]    tag;           // one bit per read travelling through the ROM
   logic [ROM_LAT-1:0]    tag_next;
   logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      buf_count;
   logic                  push;
   logic                  pop;
   logic                  issue;
   int                    in_flight;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w.valid = (buf_count != '0);
   assign w.data  = buf_mem[rd_ptr];
   assign w.last  = w.valid && (accept_left == ONE);
   assign pop     = w.valid & w.ready;
   assign push    = tag[ROM_LAT-1];

   // Credit check: issue only if every read already committed still fits the FIFO.
   always_comb begin
      // NOTE: every signal driven here gets a default first so no latch is inferred.
      in_flight = 0;
      tag_next  = tag << 1;
      for (int i = 0; i < ROM_LAT; i++) in_flight += int'(tag[i]);
      issue       = (state == FETCH) &&
                    ((in_flight + int'(buf_count) - int'(pop)) < BUF_DEPTH);
      tag_next[0] = issue;
   end

   // Burst control FSM with registered rom_addr, busy and done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rom_addr    <= '0;
         issue_left  <= '0;
         accept_left <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values.
         done <= 1'b0;
         if (pop) accept_left <= accept_left - 1'b1;
         case (state)
            IDLE: begin
               if (start) begin
                  if (word_cnt != '0) begin
                     state       <= FETCH;
                     rom_addr    <= base_addr;
                     issue_left  <= word_cnt;
                     accept_left <= word_cnt;
                     busy        <= 1'b1;
                  end else begin
                     state <= FIN;
                     done  <= 1'b1;
                  end
               end
            end
            FETCH: begin
               // rom_addr is read during this cycle; advancing it marks the issue.
               if (issue) begin
                  rom_addr   <= rom_addr + 1'b1;
                  issue_left <= issue_left - 1'b1;
                  if (issue_left == ONE) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop && w.last) begin
                  state <= FIN;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            FIN: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Tag shift register: a set bit at the top means rom_rd_data is a live word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tag <= '0;
      else        tag <= tag_next;
   end

   // FIFO pointers and occupancy; simultaneous push and pop are allowed even when full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         buf_count <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         buf_count <= buf_count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // FIFO storage captures returning ROM data.
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; buf_count alone decides which entries are valid.
      if (push) buf_mem[wr_ptr] <= rom_rd_data;
   end

endmodule

// File: tb/tb_conv_weight_fetch.sv
// Scoreboard bench: two instances (ROM latency 1 and 2) share stimulus;
// expected words are queued at start and popped by a monitor on accepts.
module tb_conv_weight_fetch;

   localparam int AW = 8;
   localparam int DW = 144;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          w_ready = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   word_cnt = '0;
   logic [AW-1:0] rom_addr0, rom_addr1;
   logic [DW-1:0] rom0_q, rom1_a, rom1_b;
   logic          busy0, busy1, done0, done1;

   conv_weight_fetch_if #(.DATA_WIDTH(DW)) w0 ();
   conv_weight_fetch_if #(.DATA_WIDTH(DW)) w1 ();
   assign w0.ready = w_ready;
   assign w1.ready = w_ready;

   always #5 clk = ~clk;

   conv_weight_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LAT(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .word_cnt(word_cnt), .rom_addr(rom_addr0), .rom_rd_data(rom0_q),
      .w(w0), .busy(busy0), .done(done0));

   conv_weight_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LAT(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .word_cnt(word_cnt), .rom_addr(rom_addr1), .rom_rd_data(rom1_b),
      .w(w1), .busy(busy1), .done(done1));

   // ROM content: tap k of word a holds {k, 0, a}, so tap order and address are both visible.
   function automatic logic [DW-1:0] word_of(input logic [7:0] a);
      logic [DW-1:0] r;
      r = '0;
      for (int k = 0; k < 9; k++) r[16*k +: 16] = {4'(k), 4'h0, a};
      return r;
   endfunction

   always @(posedge clk) rom0_q <= word_of(rom_addr0);
   always @(posedge clk) begin
      rom1_a <= word_of(rom_addr1);
      rom1_b <= rom1_a;
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int mode = 0;   // 0: ready high, 1: ready 1,0,0 pattern, 2: random ready
   int pat = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Ready is changed just after the active edge so the monitor sees it settled.
   always @(posedge clk) begin
      #1;
      case (mode)
         0: w_ready = 1'b1;
         1: begin w_ready = (pat % 3 == 0); pat++; end
         default: w_ready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   logic [7:0] exp_q0[$];
   logic [7:0] exp_q1[$];

   function automatic int qsize(input int l);
      return (l == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   function automatic logic [7:0] qpop(input int l);
      if (l == 0) return exp_q0.pop_front();
      return exp_q1.pop_front();
   endfunction

   logic          m_valid [2];
   logic          m_last  [2];
   logic          m_done  [2];
   logic          m_busy  [2];
   logic [DW-1:0] m_data  [2];
   assign m_valid[0] = w0.valid;  assign m_valid[1] = w1.valid;
   assign m_last[0]  = w0.last;   assign m_last[1]  = w1.last;
   assign m_data[0]  = w0.data;   assign m_data[1]  = w1.data;
   assign m_done[0]  = done0;     assign m_done[1]  = done1;
   assign m_busy[0]  = busy0;     assign m_busy[1]  = busy1;

   int            start_cyc [2];
   int            prev_acc  [2];
   int            exp_done  [2] = '{-1, -1};
   int            done_cnt  [2];
   int            acc_cnt   [2];
   bit            first_v   [2];
   bit            first_acc [2];
   bit            stall_prev[2];
   logic [DW-1:0] prev_data [2];
   logic [7:0]    mon_addr;

   // Monitor: compares every accepted word and every done pulse with the scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int l = 0; l < 2; l++) stall_prev[l] = 1'b0;
      end else begin
         for (int l = 0; l < 2; l++) begin
            if (stall_prev[l]) begin
               check("stall_valid_held", m_valid[l], 1'b1);
               check("stall_data_stable", m_data[l], prev_data[l]);
            end
            if (m_valid[l]) begin
               if (first_v[l]) begin
                  check("first_valid_latency", cyc, start_cyc[l] + l + 2);
                  first_v[l] = 1'b0;
               end
               if (qsize(l) == 0) begin
                  check("spurious_valid", m_valid[l], 1'b0);
               end else if (w_ready) begin
                  mon_addr = qpop(l);
                  check("word_data", m_data[l], word_of(mon_addr));
                  check("word_last", m_last[l], qsize(l) == 0);
                  if (mode == 0 && !first_acc[l])
                     check("no_bubble", cyc, prev_acc[l] + 1);
                  first_acc[l] = 1'b0;
                  prev_acc[l]  = cyc;
                  acc_cnt[l]++;
                  if (qsize(l) == 0) exp_done[l] = cyc + 1;
               end
            end
            stall_prev[l] = m_valid[l] & ~w_ready;
            prev_data[l]  = m_data[l];
            if (m_done[l] || exp_done[l] == cyc) begin
               check("done_pulse", m_done[l], exp_done[l] == cyc);
               check("busy_low_with_done", m_busy[l], 1'b0);
               if (m_done[l]) done_cnt[l]++;
               if (exp_done[l] == cyc) exp_done[l] = -1;
            end
         end
         check("buf_bound_lat1", dut0.buf_count <= 2, 1'b1);
         check("buf_bound_lat2", dut1.buf_count <= 3, 1'b1);
      end
   end

   // Pulse start and load the scoreboard with the addresses the burst must return.
   task automatic issue_start(input logic [7:0] b, input int n);
      int t;
      t = 0;
      while ((busy0 || busy1) && t < 100) begin @(negedge clk); t++; end
      @(negedge clk);
      start     = 1'b1;
      base_addr = b;
      word_cnt  = (AW + 1)'(n);
      for (int i = 0; i < n; i++) begin
         exp_q0.push_back(b + 8'(i));
         exp_q1.push_back(b + 8'(i));
      end
      for (int l = 0; l < 2; l++) begin
         start_cyc[l] = cyc + 1;
         first_v[l]   = (n != 0);
         first_acc[l] = 1'b1;
         acc_cnt[l]   = 0;
         done_cnt[l]  = 0;
         exp_done[l]  = (n == 0) ? cyc + 1 : -1;
      end
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start_lat1", busy0, n != 0);
      check("busy_after_start_lat2", busy1, n != 0);
   endtask

   task automatic run_burst(input logic [7:0] b, input int n, input int md, input bit extra);
      int t;
      mode = md;
      pat  = 0;
      issue_start(b, n);
      if (extra) begin
         repeat (2) @(negedge clk);
         start     = 1'b1;
         base_addr = 8'h80;
         word_cnt  = 9'd3;
         @(negedge clk);
         start = 1'b0;
      end
      t = 0;
      while ((done_cnt[0] == 0 || done_cnt[1] == 0) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("burst_completes", t < 2000, 1'b1);
      repeat (3) @(negedge clk);
      check("scoreboard_empty_lat1", exp_q0.size(), 0);
      check("scoreboard_empty_lat2", exp_q1.size(), 0);
      check("single_done_lat1", done_cnt[0], 1);
      check("single_done_lat2", done_cnt[1], 1);
      exp_q0.delete();
      exp_q1.delete();
   endtask

   task automatic check_reset_outputs();
      check("rst_valid_lat1", w0.valid, 1'b0);
      check("rst_valid_lat2", w1.valid, 1'b0);
      check("rst_last_lat1", w0.last, 1'b0);
      check("rst_last_lat2", w1.last, 1'b0);
      check("rst_busy", {busy0, busy1}, 2'b00);
      check("rst_done", {done0, done1}, 2'b00);
      check("rst_rom_addr_lat1", rom_addr0, 8'h00);
      check("rst_rom_addr_lat2", rom_addr1, 8'h00);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] a0, a1;
      int t;

      #3;
      check_reset_outputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic burst, wrap-around, backpressure, latched parameters.
      run_burst(8'h10, 5, 0, 1'b0);
      run_burst(8'hFE, 4, 0, 1'b0);
      run_burst(8'h00, 8, 1, 1'b0);
      run_burst(8'h30, 12, 0, 1'b1);

      // Empty burst: no reads, no words, one done.
      a0 = rom_addr0;
      a1 = rom_addr1;
      run_burst(8'h55, 0, 0, 1'b0);
      check("cnt0_rom_addr_lat1", rom_addr0, a0);
      check("cnt0_rom_addr_lat2", rom_addr1, a1);

      // Full 256-word burst at full rate.
      run_burst(8'h00, 256, 0, 1'b0);

      // Randomized bursts and ready patterns.
      for (int r = 0; r < 8; r++)
         run_burst(8'($urandom), int'($urandom_range(1, 24)), int'($urandom_range(0, 2)), 1'b0);

      // Reset in the middle of a burst.
      mode = 0;
      issue_start(8'h20, 10);
      t = 0;
      while (acc_cnt[0] < 3 && t < 200) begin @(posedge clk); t++; end
      check("reached_third_word", t < 200, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      exp_q0.delete();
      exp_q1.delete();
      for (int l = 0; l < 2; l++) begin
         exp_done[l] = -1;
         first_v[l]  = 1'b0;
         done_cnt[l] = 0;
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("no_done_after_reset", done_cnt[0] + done_cnt[1], 0);
      run_burst(8'h40, 2, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
